// File: rtl/bcd_counter_ndigit_if.sv
// Control and status bundle for the multi-digit BCD counter.
// master: the block that steers the counter (enable, direction, load).
// slave:  the counter itself, returning count and terminal/error flags.
interface bcd_counter_ndigit_if #(
  parameter int DIGITS = 3
);
  logic                  enable;
  logic                  up_dn;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic [DIGITS-1:0]     digit_tc;
  logic                  done;
  logic                  load_err;

  modport master (
    output enable, up_dn, load, load_val,
    input  count, digit_tc, done, load_err
  );

  modport slave (
    input  enable, up_dn, load, load_val,
    output count, digit_tc, done, load_err
  );
endinterface

// File: rtl/bcd_counter_ndigit.sv
// Multi-digit BCD up/down counter with validated parallel load and wrap/saturate.
// Latency: count and load_err update one edge after load/enable; digit_tc and done are combinational.
// Backpressure: none; the counter accepts a load or step on every edge, load taking priority over enable.
module bcd_counter_ndigit #(
  parameter int DIGITS   = 3,
  parameter bit SATURATE = 1'b0
) (
  input logic                 clk,
  input logic                 reset,
  bcd_counter_ndigit_if.slave bus
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]      count_q;
  logic              load_err_q;
  logic [DIGITS-1:0] is9;
  logic [DIGITS-1:0] is0;
  logic              at_tc;
  logic [W-1:0]      step_val;
  logic              carry;
  logic [W-1:0]      load_clamped;
  logic              load_bad;

  // Per-digit terminal detection, shared by the carry chain and the status flags
  always_comb begin
    is9 = '0;
    is0 = '0;
    for (int i = 0; i < DIGITS; i++) begin
      is9[i] = (count_q[4*i +: 4] == 4'd9);
      is0[i] = (count_q[4*i +: 4] == 4'd0);
    end
  end

  // Terminal count follows the current direction, independent of enable
  assign at_tc        = bus.up_dn ? (&is9) : (&is0);
  assign bus.digit_tc = bus.up_dn ? is9 : is0;
  assign bus.done     = at_tc;
  assign bus.count    = count_q;
  assign bus.load_err = load_err_q;

  // Whole-count step in one edge: a digit moves only when every lower digit is terminal
  always_comb begin
    step_val = count_q;
    carry    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (bus.up_dn) begin
          step_val[4*i +: 4] = is9[i] ? 4'd0 : count_q[4*i +: 4] + 4'd1;
        end else begin
          step_val[4*i +: 4] = is0[i] ? 4'd9 : count_q[4*i +: 4] - 4'd1;
        end
      end
      carry = carry & (bus.up_dn ? is9[i] : is0[i]);
    end
  end

  // Clamp illegal load nibbles to 9 so the count can never leave BCD
  always_comb begin
    load_clamped = bus.load_val;
    load_bad     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) begin
        load_clamped[4*i +: 4] = 4'd9;
        load_bad               = 1'b1;
      end
    end
  end

  // Count register: load beats enable; saturation freezes at the terminal of the current direction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= bus.load & load_bad;
      if (bus.load) begin
        count_q <= load_clamped;
      end else if (bus.enable && !(SATURATE && at_tc)) begin
        count_q <= step_val;
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Bench for bcd_counter_ndigit: a wrapping and a saturating instance share stimulus.
// The reference keeps each count as a plain integer 0..999 and derives BCD and flags from it.
module tb_bcd_counter_ndigit;

  localparam int D    = 3;
  localparam int MAXV = 999;

  logic clk = 1'b0;
  logic reset;

  bcd_counter_ndigit_if #(.DIGITS(D)) bus0 ();
  bcd_counter_ndigit_if #(.DIGITS(D)) bus1 ();

  bcd_counter_ndigit #(.DIGITS(D), .SATURATE(1'b0)) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  bcd_counter_ndigit #(.DIGITS(D), .SATURATE(1'b1)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int m0     = 0;   // wrapping instance value
  int m1     = 0;   // saturating instance value
  bit err_exp = 1'b0;
  bit cmp_on  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int div;
    r   = '0;
    div = 1;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'((v / div) % 10);
      div = div * 10;
    end
    return r;
  endfunction

  function automatic logic [D-1:0] exp_tc(input int v, input bit up);
    logic [D-1:0] r;
    int div;
    int dig;
    r   = '0;
    div = 1;
    for (int i = 0; i < D; i++) begin
      dig  = (v / div) % 10;
      r[i] = up ? (dig == 9) : (dig == 0);
      div  = div * 10;
    end
    return r;
  endfunction

  function automatic int load_value(input logic [11:0] lv);
    int v;
    int nib;
    int scale;
    v     = 0;
    scale = 1;
    for (int i = 0; i < D; i++) begin
      nib = int'(lv[4*i +: 4]);
      if (nib > 9) nib = 9;
      v     = v + nib * scale;
      scale = scale * 10;
    end
    return v;
  endfunction

  function automatic bit load_has_bad(input logic [11:0] lv);
    bit b;
    b = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (lv[4*i +: 4] > 4'd9) b = 1'b1;
    end
    return b;
  endfunction

  function automatic int next_val(input int m, input bit sat, input bit en,
                                  input bit up, input bit ld, input logic [11:0] lv);
    if (ld) return load_value(lv);
    if (!en) return m;
    if (up) begin
      if (m == MAXV) return sat ? m : 0;
      return m + 1;
    end
    if (m == 0) return sat ? 0 : MAXV;
    return m - 1;
  endfunction

  task automatic cmp_dut(input string pfx, input logic [11:0] cnt, input logic [D-1:0] tc,
                         input logic dn, input logic er, input int m, input bit up);
    bit ok;
    chk({pfx, "_count"},    cnt, to_bcd(m));
    chk({pfx, "_digit_tc"}, tc,  exp_tc(m, up));
    chk({pfx, "_done"},     dn,  up ? (m == MAXV) : (m == 0));
    chk({pfx, "_load_err"}, er,  err_exp);
    ok = 1'b1;
    for (int i = 0; i < D; i++) begin
      if (!(cnt[4*i +: 4] <= 4'd9)) ok = 1'b0;
    end
    chk({pfx, "_bcd_invariant"}, ok, 1'b1);
  endtask

  // Compare both instances against the reference on every falling edge
  always @(negedge clk) begin
    if (cmp_on) begin
      cmp_dut("wrap", bus0.count, bus0.digit_tc, bus0.done, bus0.load_err, m0, bus0.up_dn);
      cmp_dut("sat",  bus1.count, bus1.digit_tc, bus1.done, bus1.load_err, m1, bus1.up_dn);
    end
  end

  task automatic drive(input bit en, input bit up, input bit ld, input logic [11:0] lv);
    bus0.enable = en; bus0.up_dn = up; bus0.load = ld; bus0.load_val = lv;
    bus1.enable = en; bus1.up_dn = up; bus1.load = ld; bus1.load_val = lv;
  endtask

  task automatic cycle(input bit en, input bit up, input bit ld, input logic [11:0] lv);
    drive(en, up, ld, lv);
    @(posedge clk);
    m0      = next_val(m0, 1'b0, en, up, ld, lv);
    m1      = next_val(m1, 1'b1, en, up, ld, lv);
    err_exp = ld && load_has_bad(lv);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 12'h000);
    cmp_on = 1'b1;
    #2;
    chk("rst_count",    bus0.count, 12'h000);
    chk("rst_load_err", bus0.load_err, 1'b0);
    chk("rst_done_dn",  bus0.done, 1'b1);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    // 1: full up sweep with wrap
    for (int k = 0; k < 1000; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 12'h000);
      if (k == 0) begin
        chk("t1_first", bus0.count, 12'h001);
        chk("t1_first_done", bus0.done, 1'b0);
      end
      if (k == 998) begin
        chk("t1_999", bus0.count, 12'h999);
        chk("t1_999_done", bus0.done, 1'b1);
      end
      if (k == 999) chk("t1_wrap", bus0.count, 12'h000);
    end

    // 2: multi-digit carry in one edge
    cycle(1'b0, 1'b1, 1'b1, 12'h199);
    chk("t2_load", bus0.count, 12'h199);
    chk("t2_tc", bus0.digit_tc, 3'b011);
    cycle(1'b1, 1'b1, 1'b0, 12'h000);
    chk("t2_carry", bus0.count, 12'h200);

    // hold with enable low
    cycle(1'b0, 1'b1, 1'b0, 12'h000);
    chk("hold", bus0.count, 12'h200);

    // 3: borrow and down wrap
    cycle(1'b0, 1'b0, 1'b1, 12'h100);
    cycle(1'b1, 1'b0, 1'b0, 12'h000);
    chk("t3_borrow", bus0.count, 12'h099);
    cycle(1'b0, 1'b0, 1'b1, 12'h000);
    chk("t3_done", bus0.done, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 12'h000);
    chk("t3_wrap", bus0.count, 12'h999);
    chk("t3_sat_hold0", bus1.count, 12'h000);

    // 4: saturation in both directions
    cycle(1'b0, 1'b1, 1'b1, 12'h999);
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 12'h000);
    chk("t4_sat999", bus1.count, 12'h999);
    chk("t4_wrap009", bus0.count, 12'h009);
    cycle(1'b1, 1'b0, 1'b0, 12'h000);
    chk("t4_sat998", bus1.count, 12'h998);
    cycle(1'b0, 1'b0, 1'b1, 12'h000);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 12'h000);
    chk("t4_sat000", bus1.count, 12'h000);
    chk("t4_wrap995", bus0.count, 12'h995);

    // 5: illegal nibble clamping and one-cycle error pulse
    cycle(1'b1, 1'b1, 1'b1, 12'h1A9);
    chk("t5_clamp", bus0.count, 12'h199);
    chk("t5_err", bus0.load_err, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 12'h000);
    chk("t5_err_pulse", bus0.load_err, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 12'h123);
    chk("t5_good_load", bus1.count, 12'h123);
    chk("t5_good_err", bus1.load_err, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 12'hF0A);
    chk("t5_clamp2", bus0.count, 12'h909);
    chk("t5_err2", bus1.load_err, 1'b1);

    // 6: asynchronous reset mid-cycle
    cycle(1'b0, 1'b1, 1'b1, 12'h537);
    chk("t6_load", bus0.count, 12'h537);
    #2;
    reset   = 1'b0;
    m0      = 0;
    m1      = 0;
    err_exp = 1'b0;
    #1;
    chk("t6_async_wrap", bus0.count, 12'h000);
    chk("t6_async_sat",  bus1.count, 12'h000);
    #3 reset = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 12'h000);
    chk("t6_after", bus0.count, 12'h001);

    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
